// File: rtl/lpc_io_dispatch_pkg.sv
// Shared types and helpers for the LPC I/O dispatcher.
package lpc_io_dispatch_pkg;

  // Dispatcher FSM encodings (3-bit).
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdWait = 3'd1,
    StRdDone = 3'd2,
    StWrWait = 3'd3,
    StWrDone = 3'd4
  } disp_state_e;

  // Width of the target-ack timeout counter.
  localparam int unsigned CntW = 8;

  // Address window match: compare only the bits the mask keeps.
  function automatic logic addr_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/lpc_io_dispatch_irq_arb.sv
// Registered priority arbiter: merges per-target IRQ levels onto one vector/flag pair.
module lpc_io_dispatch_irq_arb #(
  parameter int unsigned NTgt = 2
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [NTgt-1:0]   irq_i,
  input  logic [4*NTgt-1:0] irq_num_i,
  output logic [3:0]        irq_num_o,
  output logic              interrupt_o
);

  logic [3:0] num_q, num_d;
  logic       int_q;

  // Lowest asserted index wins; with nothing asserted the last vector is held.
  always_comb begin
    num_d = num_q;
    for (int i = int'(NTgt) - 1; i >= 0; i--) begin
      if (irq_i[i]) num_d = irq_num_i[4*i +: 4];
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      num_q <= 4'd0;
      int_q <= 1'b0;
    end else begin
      num_q <= num_d;
      int_q <= |irq_i;
    end
  end

  assign irq_num_o   = num_q;
  assign interrupt_o = int_q;

endmodule

// File: rtl/lpc_io_dispatch.sv
// Routes lpc_periph I/O reads/writes to one of NTgt register-file targets and merges their IRQs.
module lpc_io_dispatch
  import lpc_io_dispatch_pkg::*;
#(
  parameter int unsigned         NTgt      = 2,
  parameter logic [NTgt*16-1:0]  TgtBase   = {16'h0FE0, 16'h03F8},
  parameter logic [NTgt*16-1:0]  TgtMask   = {16'hFFE0, 16'hFFF8},
  parameter int unsigned         Timeout   = 255,
  parameter logic [7:0]          DfltRdata = 8'hFF
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [15:0]       lpc_addr_i,
  input  logic [7:0]        lpc_wdata_i,
  input  logic              lpc_data_wr_i,
  output logic              lpc_wr_done_o,
  input  logic              lpc_data_req_i,
  output logic              lpc_data_rd_o,
  output logic [7:0]        lpc_rdata_o,
  output logic [3:0]        irq_num_o,
  output logic              interrupt_o,
  output logic [NTgt-1:0]   tgt_req_o,
  output logic              tgt_we_o,
  output logic [15:0]       tgt_addr_o,
  output logic [7:0]        tgt_wdata_o,
  input  logic [8*NTgt-1:0] tgt_rdata_i,
  input  logic [NTgt-1:0]   tgt_ack_i,
  input  logic [NTgt-1:0]   tgt_irq_i,
  input  logic [4*NTgt-1:0] tgt_irq_num_i,
  output logic              err_o
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(Timeout);

  disp_state_e     state_q, state_d;
  logic            req_q, wr_q;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [NTgt-1:0] tgt_req_q, tgt_req_d;
  logic            we_q, we_d;
  logic            rd_q, rd_d;
  logic            wr_done_q, wr_done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NTgt-1:0] hit_sel;
  logic            hit_any;
  logic [7:0]      sel_rdata;
  logic            ack_sel, rise_rd, rise_wr;

  assign rise_rd = lpc_data_req_i & ~req_q;
  assign rise_wr = lpc_data_wr_i & ~wr_q;
  // tgt_req_q doubles as the selection, so acks from other targets never count.
  assign ack_sel = |(tgt_ack_i & tgt_req_q);

  // Address decode on the live address: lowest-index matching window wins.
  always_comb begin
    hit_sel = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NTgt; i++) begin
      if (!hit_any && addr_hit(lpc_addr_i, TgtBase[16*i +: 16], TgtMask[16*i +: 16])) begin
        hit_sel[i] = 1'b1;
        hit_any    = 1'b1;
      end
    end
  end

  // Read data mux for the currently selected target.
  always_comb begin
    sel_rdata = DfltRdata;
    for (int unsigned i = 0; i < NTgt; i++) begin
      if (tgt_req_q[i]) sel_rdata = tgt_rdata_i[8*i +: 8];
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tgt_req_d = tgt_req_q;
    we_d      = we_q;
    rd_d      = rd_q;
    wr_done_d = wr_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise_wr) begin
          // Write wins if both strobes rise together.
          addr_d  = lpc_addr_i;
          wdata_d = lpc_wdata_i;
          cnt_d   = '0;
          we_d    = 1'b1;
          if (hit_any) begin
            tgt_req_d = hit_sel;
            state_d   = StWrWait;
          end else begin
            err_d     = 1'b1;
            wr_done_d = 1'b1;
            state_d   = StWrDone;
          end
        end else if (rise_rd) begin
          addr_d = lpc_addr_i;
          cnt_d  = '0;
          we_d   = 1'b0;
          if (hit_any) begin
            tgt_req_d = hit_sel;
            state_d   = StRdWait;
          end else begin
            rdata_d = DfltRdata;
            rd_d    = 1'b1;
            err_d   = 1'b1;
            state_d = StRdDone;
          end
        end
      end
      StRdWait: begin
        if (!lpc_data_req_i) begin
          tgt_req_d = '0;
          rd_d      = 1'b0;
          state_d   = StIdle;
        end else if (ack_sel) begin
          rdata_d   = sel_rdata;
          tgt_req_d = '0;
          rd_d      = 1'b1;
          state_d   = StRdDone;
        end else if (cnt_q == TimeoutCnt) begin
          rdata_d   = DfltRdata;
          err_d     = 1'b1;
          tgt_req_d = '0;
          rd_d      = 1'b1;
          state_d   = StRdDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdDone: begin
        if (!lpc_data_req_i) begin
          rd_d    = 1'b0;
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (!lpc_data_wr_i) begin
          tgt_req_d = '0;
          wr_done_d = 1'b0;
          state_d   = StIdle;
        end else if (ack_sel || (cnt_q == TimeoutCnt)) begin
          if (!ack_sel) err_d = 1'b1;
          tgt_req_d = '0;
          wr_done_d = 1'b1;
          state_d   = StWrDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrDone: begin
        if (!lpc_data_wr_i) begin
          wr_done_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        tgt_req_d = '0;
        rd_d      = 1'b0;
        wr_done_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tgt_req_q <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_done_q <= 1'b0;
      rdata_q   <= DfltRdata;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= lpc_data_req_i;
      wr_q      <= lpc_data_wr_i;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tgt_req_q <= tgt_req_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wr_done_q <= wr_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign lpc_wr_done_o = wr_done_q;
  assign lpc_data_rd_o = rd_q;
  assign lpc_rdata_o   = rdata_q;
  assign tgt_req_o     = tgt_req_q;
  assign tgt_we_o      = we_q;
  assign tgt_addr_o    = addr_q;
  assign tgt_wdata_o   = wdata_q;
  assign err_o         = err_q;

  lpc_io_dispatch_irq_arb #(
    .NTgt(NTgt)
  ) u_irq_arb (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .irq_i      (tgt_irq_i),
    .irq_num_i  (tgt_irq_num_i),
    .irq_num_o  (irq_num_o),
    .interrupt_o(interrupt_o)
  );

endmodule

// File: tb/tb_lpc_io_dispatch.sv
// Directed bench for lpc_io_dispatch: reads, writes, unmapped access, timeout, abort, IRQ merge.
module tb_lpc_io_dispatch;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic [15:0] lpc_addr_i;
  logic [7:0]  lpc_wdata_i;
  logic        lpc_data_wr_i;
  logic        lpc_wr_done_o;
  logic        lpc_data_req_i;
  logic        lpc_data_rd_o;
  logic [7:0]  lpc_rdata_o;
  logic [3:0]  irq_num_o;
  logic        interrupt_o;
  logic [1:0]  tgt_req_o;
  logic        tgt_we_o;
  logic [15:0] tgt_addr_o;
  logic [7:0]  tgt_wdata_o;
  logic [15:0] tgt_rdata_i;
  logic [1:0]  tgt_ack_i;
  logic [1:0]  tgt_irq_i;
  logic [7:0]  tgt_irq_num_i;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  // Target 0 is the TPM window (0x0FE0/32), target 1 the UART window (0x03F8/8).
  lpc_io_dispatch #(
    .NTgt   (2),
    .TgtBase({16'h03F8, 16'h0FE0}),
    .TgtMask({16'hFFF8, 16'hFFE0})
  ) dut (
    .clk_i         (clk_i),
    .nrst_i        (nrst_i),
    .lpc_addr_i    (lpc_addr_i),
    .lpc_wdata_i   (lpc_wdata_i),
    .lpc_data_wr_i (lpc_data_wr_i),
    .lpc_wr_done_o (lpc_wr_done_o),
    .lpc_data_req_i(lpc_data_req_i),
    .lpc_data_rd_o (lpc_data_rd_o),
    .lpc_rdata_o   (lpc_rdata_o),
    .irq_num_o     (irq_num_o),
    .interrupt_o   (interrupt_o),
    .tgt_req_o     (tgt_req_o),
    .tgt_we_o      (tgt_we_o),
    .tgt_addr_o    (tgt_addr_o),
    .tgt_wdata_o   (tgt_wdata_o),
    .tgt_rdata_i   (tgt_rdata_i),
    .tgt_ack_i     (tgt_ack_i),
    .tgt_irq_i     (tgt_irq_i),
    .tgt_irq_num_i (tgt_irq_num_i),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    nrst_i         = 1'b0;
    lpc_addr_i     = '0;
    lpc_wdata_i    = '0;
    lpc_data_wr_i  = 1'b0;
    lpc_data_req_i = 1'b0;
    tgt_rdata_i    = '0;
    tgt_ack_i      = '0;
    tgt_irq_i      = '0;
    tgt_irq_num_i  = '0;
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_tgt_req", 32'(tgt_req_o), 32'h0);
    check("rst_tgt_we", 32'(tgt_we_o), 32'h0);
    check("rst_rd", 32'(lpc_data_rd_o), 32'h0);
    check("rst_wr_done", 32'(lpc_wr_done_o), 32'h0);
    check("rst_rdata", 32'(lpc_rdata_o), 32'hFF);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_irq_num", 32'(irq_num_o), 32'h0);
    check("rst_interrupt", 32'(interrupt_o), 32'h0);

    // Read 0x0FE4, target 0 acks two cycles after its request.
    lpc_addr_i = 16'h0FE4;
    lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    check("t1_tgt_req", 32'(tgt_req_o), 32'h1);
    check("t1_tgt_we", 32'(tgt_we_o), 32'h0);
    check("t1_tgt_addr", 32'(tgt_addr_o), 32'h0FE4);
    check("t1_rd_early", 32'(lpc_data_rd_o), 32'h0);
    @(negedge clk_i);
    check("t1_rd_wait", 32'(lpc_data_rd_o), 32'h0);
    tgt_rdata_i = {8'h5A, 8'hA5};
    tgt_ack_i = 2'b01;
    @(negedge clk_i);
    tgt_ack_i = 2'b00;
    check("t1_rd", 32'(lpc_data_rd_o), 32'h1);
    check("t1_rdata", 32'(lpc_rdata_o), 32'hA5);
    check("t1_req_drop", 32'(tgt_req_o), 32'h0);
    repeat (2) @(negedge clk_i);
    check("t1_rd_hold", 32'(lpc_data_rd_o), 32'h1);
    check("t1_rdata_hold", 32'(lpc_rdata_o), 32'hA5);
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    check("t1_rd_clear", 32'(lpc_data_rd_o), 32'h0);
    check("t1_err", 32'(err_o), 32'h0);

    // Abort in RD_WAIT, then a late ack must be ignored.
    lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    check("t5_tgt_req", 32'(tgt_req_o), 32'h1);
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    check("t5_req_drop", 32'(tgt_req_o), 32'h0);
    check("t5_rd0", 32'(lpc_data_rd_o), 32'h0);
    tgt_rdata_i = {8'h5A, 8'h77};
    tgt_ack_i = 2'b01;
    @(negedge clk_i);
    tgt_ack_i = 2'b00;
    check("t5_rd1", 32'(lpc_data_rd_o), 32'h0);
    check("t5_rdata", 32'(lpc_rdata_o), 32'hA5);
    @(negedge clk_i);
    check("t5_rd2", 32'(lpc_data_rd_o), 32'h0);
    check("t5_err", 32'(err_o), 32'h0);

    // Write 0x03F9 <- 0x3C to target 1; a stray ack from target 0 is ignored.
    lpc_addr_i = 16'h03F9;
    lpc_wdata_i = 8'h3C;
    lpc_data_wr_i = 1'b1;
    @(negedge clk_i);
    check("t2_tgt_req", 32'(tgt_req_o), 32'h2);
    check("t2_tgt_we", 32'(tgt_we_o), 32'h1);
    check("t2_wdata", 32'(tgt_wdata_o), 32'h3C);
    check("t2_addr", 32'(tgt_addr_o), 32'h03F9);
    check("t2_done_early", 32'(lpc_wr_done_o), 32'h0);
    tgt_ack_i = 2'b01;
    @(negedge clk_i);
    tgt_ack_i = 2'b00;
    check("t2_stray_ack", 32'(lpc_wr_done_o), 32'h0);
    check("t2_req_kept", 32'(tgt_req_o), 32'h2);
    tgt_ack_i = 2'b10;
    @(negedge clk_i);
    tgt_ack_i = 2'b00;
    check("t2_done", 32'(lpc_wr_done_o), 32'h1);
    check("t2_req_drop", 32'(tgt_req_o), 32'h0);
    repeat (3) @(negedge clk_i);
    check("t2_done_hold", 32'(lpc_wr_done_o), 32'h1);
    lpc_data_wr_i = 1'b0;
    @(negedge clk_i);
    check("t2_done_clear", 32'(lpc_wr_done_o), 32'h0);
    check("t2_err", 32'(err_o), 32'h0);

    // Unmapped read 0x0080.
    lpc_addr_i = 16'h0080;
    lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    check("t3_tgt_req", 32'(tgt_req_o), 32'h0);
    check("t3_rd", 32'(lpc_data_rd_o), 32'h1);
    check("t3_rdata", 32'(lpc_rdata_o), 32'hFF);
    check("t3_err", 32'(err_o), 32'h1);
    @(negedge clk_i);
    check("t3_rd_hold", 32'(lpc_data_rd_o), 32'h1);
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    check("t3_rd_clear", 32'(lpc_data_rd_o), 32'h0);
    check("t3_err_sticky", 32'(err_o), 32'h1);

    // Timeout: preload rdata with a real value, then a target that never acks.
    do_reset();
    check("t4_err_rst", 32'(err_o), 32'h0);
    lpc_addr_i = 16'h0FE4;
    lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    tgt_rdata_i = {8'h5A, 8'hA5};
    tgt_ack_i = 2'b01;
    @(negedge clk_i);
    tgt_ack_i = 2'b00;
    check("t4_pre_rdata", 32'(lpc_rdata_o), 32'hA5);
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    check("t4_tgt_req", 32'(tgt_req_o), 32'h1);
    n = 0;
    while (!lpc_data_rd_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'd256);
    check("t4_rd", 32'(lpc_data_rd_o), 32'h1);
    check("t4_rdata", 32'(lpc_rdata_o), 32'hFF);
    check("t4_err", 32'(err_o), 32'h1);
    check("t4_req_drop", 32'(tgt_req_o), 32'h0);
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    check("t4_rd_clear", 32'(lpc_data_rd_o), 32'h0);

    // IRQ arbitration.
    tgt_irq_num_i = {4'hB, 4'h3};
    tgt_irq_i = 2'b11;
    #1;
    check("t6_latency", 32'(interrupt_o), 32'h0);
    @(negedge clk_i);
    check("t6_num_both", 32'(irq_num_o), 32'h3);
    check("t6_int_both", 32'(interrupt_o), 32'h1);
    tgt_irq_i = 2'b10;
    @(negedge clk_i);
    check("t6_num_one", 32'(irq_num_o), 32'hB);
    check("t6_int_one", 32'(interrupt_o), 32'h1);
    tgt_irq_i = 2'b00;
    @(negedge clk_i);
    check("t6_int_none", 32'(interrupt_o), 32'h0);
    check("t6_num_hold", 32'(irq_num_o), 32'hB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
